// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter using double-dabble (shift-and-add-3), one bit per clock.
// Produces packed BCD digits plus leading-zero blank flags for the 7-segment decoders.
module bin_bcd_seq #(
    parameter int N = 8,
    parameter int D = 3
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   bin_in,
    output logic           busy,
    output logic           done,
    output logic [4*D-1:0] bcd_out,
    output logic [D-1:0]   blank
);

    localparam int CW = $clog2(N + 1);
    localparam int W  = 4 * D + N;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [W-1:0]  sr;
    logic [CW-1:0] cnt;

    // One double-dabble step: correct every nibble >= 5, then shift the whole register left.
    function automatic logic [W-1:0] dabble(input logic [W-1:0] r);
        logic [W-1:0] t;
        t = r;
        for (int i = 0; i < D; i++) begin
            if (t[N+4*i +: 4] >= 4'd5)
                t[N+4*i +: 4] = t[N+4*i +: 4] + 4'd3;
        end
        return {t[W-2:0], 1'b0};
    endfunction

    // A digit is blanked when it and every more significant digit are zero; the units digit never is.
    function automatic logic [D-1:0] blank_of(input logic [4*D-1:0] d);
        logic [D-1:0] b;
        logic         z;
        b = '0;
        z = 1'b1;
        for (int i = D - 1; i >= 1; i--) begin
            z    = z & (d[4*i +: 4] == 4'd0);
            b[i] = z;
        end
        return b;
    endfunction

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (cnt == CW'(N - 1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            bcd_out <= '0;
            blank   <= blank_of('0);
            done    <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr  <= {{(4*D){1'b0}}, bin_in};
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    sr  <= dabble(sr);
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    bcd_out <= sr[W-1:N];
                    blank   <= blank_of(sr[W-1:N]);
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
